eth_fifo_wr_arbiter: RTL and testbench
======================================

# eth_fifo_wr_arbiter

Frame-level round-robin arbiter that shares the single write port of the `fifo_eth` prefetch FIFO among 2^C_ID_WIDTH Ethernet frame sources. Each source's frame is written as an unbroken run of beats, and each beat is tagged with source ID, last and error bits. A per-frame stall watchdog keeps a stalled source from locking the FIFO. The block sits in the write clock domain, directly in front of the FIFO's `wr_data`/`wr_en`/`wr_vld` port.

## Interface
- C_DATA_WIDTH, 32, payload width per beat.
- C_ID_WIDTH, 2, source index width; N = 2^C_ID_WIDTH requesters.
- C_TIMEOUT, 255, mid-frame stall limit in cycles; 0 disables the watchdog. Counter width is 16 bits, so the legal range is 0..65535.
- clk  in  1  write-domain clock, same as the FIFO `wr_clk`.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N  per-source beat valid.
- req_data  in  N*C_DATA_WIDTH  per-source payload; source i occupies bits [i*C_DATA_WIDTH +: C_DATA_WIDTH].
- req_last  in  N  per-source end-of-frame marker.
- req_ready  out  N  per-source beat accepted (consumed) this cycle when the matching req_valid is also high.
- fifo_wr_data  out  C_DATA_WIDTH+C_ID_WIDTH+2  {err, last, id, payload}; connects to the FIFO `wr_data`.
- fifo_wr_en  out  1  write strobe; connects to the FIFO `wr_en`.
- fifo_wr_vld  in  1  FIFO not full; driven from the FIFO `wr_vld`.
- grant_id  out  C_ID_WIDTH  currently granted source.
- busy  out  1  high while in XFER or ABORT.
- err_timeout  out  1  one-cycle pulse when a frame is aborted.

## Operation
- States:
  - IDLE: no source granted.
  - XFER: granted source streams its frame.
  - ABORT: terminating error beat is being written.
- Eligible set: req_valid[i] & ~drop[i].
- IDLE → XFER when the eligible set is non-empty.
  - Grant goes to the first eligible index searching upward from rr_ptr, modulo N.
  - grant_id is registered at this transition.
- XFER beat handling:
  - req_ready[g] = fifo_wr_vld.
  - fifo_wr_en = req_valid[g] & fifo_wr_vld.
  - fifo_wr_data = {1'b0, req_last[g], g, req_data[g]}, combinational pass-through.
- XFER → IDLE when a beat with req_last[g] = 1 is written. On the same edge, rr_ptr <= g+1 (wraps naturally).
- Watchdog (XFER only):
  - stall_cnt increments on cycles with req_valid[g] = 0.
  - Clears on any written beat.
  - Holds while req_valid[g] = 1 and fifo_wr_vld = 0; back-pressure from the FIFO never counts as a stall.
  - When stall_cnt == C_TIMEOUT and C_TIMEOUT != 0, go to ABORT.
- ABORT:
  - fifo_wr_en = fifo_wr_vld.
  - fifo_wr_data = {1'b1, 1'b1, g, 0}.
  - All req_ready = 0.
  - On the write: ABORT → IDLE, drop[g] <= 1, err_timeout pulses, rr_ptr <= g+1.
- Drop mode for source i:
  - req_ready[i] = 1 and beats are discarded (never written).
  - drop[i] clears on an accepted beat with req_last[i] = 1.
  - The source is excluded from arbitration while drop[i] is set.
- Non-granted, non-dropping sources: req_ready = 0.
- Reset values:
  - State IDLE; rr_ptr, grant_id, stall_cnt = 0; drop = 0.
  - busy, err_timeout, fifo_wr_en, req_ready = 0.
  - fifo_wr_data = 0.

## Timing
- Arbitration latency:
  - valid seen in IDLE at cycle t → first beat can be written at t+1.
  - last beat written at t → IDLE at t+1 → next grant's first beat at t+2.
  - This gives exactly one bubble between frames.
- Data path adds zero cycles; the FIFO itself adds its own write-to-read latency.
- Single-beat frame (valid & last in the first XFER cycle): XFER lasts 1 cycle.
- FIFO full mid-frame: the grant is held indefinitely, with no timeout.
- Simultaneous requests: strict rotation. After source g finishes or aborts, g has lowest priority.
- Timeout boundary: ABORT is entered on the edge where stall_cnt reaches C_TIMEOUT. Example: C_TIMEOUT=3 → 3 idle cycles, then ABORT.
- valid returning in the same cycle the timeout hits: ABORT wins; that beat is not accepted.
- Reset asserted mid-frame: immediate return to reset values. No terminating beat is written; downstream flushes the FIFO on the same reset.

## Test plan
- Single source 0 sends a 4-beat frame, payloads 0x11..0x14, FIFO never full → four writes on consecutive cycles starting 1 cycle after the first valid. Tags id=0, last only on 0x14, err=0.
- Sources 0, 1 and 3 hold valid with 2-beat frames simultaneously from reset → grant order 0, 1, 3, 0, …, with one idle cycle between frames and no beat interleaving.
- fifo_wr_vld low for 20 cycles in the middle of a frame, C_TIMEOUT=3 → no writes and no abort; the frame resumes intact.
- Source 2 stalls 3 cycles after beat 2, C_TIMEOUT=3 → error beat {err=1, last=1, id=2, 0} written and err_timeout pulses once. Source 2's next 5 beats, ending in last, are consumed with no FIFO writes; source 2 then arbitrates normally.
- Reset pulsed during beat 3 of a 6-beat frame → all outputs at reset values within the reset cycle. After release, a fresh frame is granted starting from rr_ptr=0.
- C_TIMEOUT=0 with source 1 stalled 1000 cycles mid-frame → the grant is held and err_timeout never pulses.

Source files
------------

// File: rtl/eth_fifo_wr_arbiter.sv
// Frame-level round-robin arbiter sharing one FIFO write port among 2^C_ID_WIDTH
// sources, with a mid-frame stall watchdog that aborts and drains a stuck source.

module eth_fifo_wr_arb_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic last,
  input  logic granted,
  input  logic in_abort,
  input  logic abort_set,
  input  logic fifo_wr_vld,
  output logic ready,
  output logic eligible
);
  logic drop;

  // A dropping source is drained at full rate, but not while the error beat is pending.
  always_comb begin
    ready = 1'b0;
    if (!in_abort) begin
      if (drop)         ready = 1'b1;
      else if (granted) ready = fifo_wr_vld;
    end
  end

  assign eligible = valid & ~drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            drop <= 1'b0;
    else if (abort_set)                    drop <= 1'b1;
    else if (drop && valid && ready && last) drop <= 1'b0;
  end
endmodule

module eth_fifo_wr_arbiter #(
  parameter  int C_DATA_WIDTH = 32,
  parameter  int C_ID_WIDTH   = 2,
  parameter  int C_TIMEOUT    = 255,
  localparam int N            = 2**C_ID_WIDTH,
  localparam int W            = C_DATA_WIDTH + C_ID_WIDTH + 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0]              req_valid,
  input  logic [N*C_DATA_WIDTH-1:0] req_data,
  input  logic [N-1:0]              req_last,
  output logic [N-1:0]              req_ready,
  output logic [W-1:0]              fifo_wr_data,
  output logic                      fifo_wr_en,
  input  logic                      fifo_wr_vld,
  output logic [C_ID_WIDTH-1:0]     grant_id,
  output logic                      busy,
  output logic                      err_timeout
);
  typedef enum logic [1:0] {IDLE, XFER, ABORT} state_t;

  state_t                  state, state_nxt;
  logic [C_ID_WIDTH-1:0]   rr_ptr, pick_id;
  logic [15:0]             stall_cnt;
  logic [N-1:0]            elig;
  logic                    pick_vld;
  logic                    g_valid, g_last, beat_wr, stall_hit, abort_wr, frame_end;
  logic [C_DATA_WIDTH-1:0] g_data;

  assign g_valid   = req_valid[grant_id];
  assign g_last    = req_last[grant_id];
  assign g_data    = req_data[int'(grant_id)*C_DATA_WIDTH +: C_DATA_WIDTH];
  assign beat_wr   = (state == XFER) && g_valid && fifo_wr_vld;
  assign abort_wr  = (state == ABORT) && fifo_wr_vld;
  assign frame_end = (beat_wr && g_last) || abort_wr;
  // Abort on the edge where the stall count reaches the limit, not one cycle later.
  assign stall_hit = (C_TIMEOUT != 0) && (state == XFER) && !g_valid &&
                     (({1'b0, stall_cnt} + 17'd1) == 17'(C_TIMEOUT));

  always_comb begin
    pick_vld = 1'b0;
    pick_id  = rr_ptr;
    // Walk downward so the nearest index above rr_ptr is the one left standing.
    for (int k = N-1; k >= 0; k--) begin
      if (elig[rr_ptr + C_ID_WIDTH'(k)]) begin
        pick_vld = 1'b1;
        pick_id  = rr_ptr + C_ID_WIDTH'(k);
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    eth_fifo_wr_arb_lane u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid       (req_valid[i]),
      .last        (req_last[i]),
      .granted     ((state == XFER) && (grant_id == C_ID_WIDTH'(i))),
      .in_abort    (state == ABORT),
      .abort_set   (abort_wr && (grant_id == C_ID_WIDTH'(i))),
      .fifo_wr_vld (fifo_wr_vld),
      .ready       (req_ready[i]),
      .eligible    (elig[i])
    );
  end

  always_comb begin
    state_nxt    = state;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    err_timeout  = 1'b0;
    case (state)
      IDLE:  if (pick_vld) state_nxt = XFER;
      XFER: begin
        fifo_wr_en   = beat_wr;
        fifo_wr_data = {1'b0, g_last, grant_id, g_data};
        if (beat_wr && g_last) state_nxt = IDLE;
        else if (stall_hit)    state_nxt = ABORT;
      end
      ABORT: begin
        fifo_wr_en   = fifo_wr_vld;
        fifo_wr_data = {1'b1, 1'b1, grant_id, {C_DATA_WIDTH{1'b0}}};
        err_timeout  = fifo_wr_vld;
        if (fifo_wr_vld) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_vld) grant_id <= pick_id;
      if (frame_end) rr_ptr <= grant_id + 1'b1;
      if (state != XFER || beat_wr) stall_cnt <= '0;
      else if (!g_valid)            stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_eth_fifo_wr_arbiter.sv
// Directed bench for eth_fifo_wr_arbiter: per-source beat buffers feed the DUT and a
// queue of expected FIFO words is checked in order as writes appear.
module tb_eth_fifo_wr_arbiter;
  localparam int DW = 32, IW = 2, N = 4, W = DW + IW + 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0, req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            fifo_wr_vld = 1'b1;

  logic [N-1:0]  req_ready, nt_ready;
  logic [W-1:0]  fifo_wr_data, nt_wr_data;
  logic          fifo_wr_en, nt_wr_en, busy, nt_busy, err_timeout, nt_err;
  logic [IW-1:0] grant_id, nt_grant;

  eth_fifo_wr_arbiter #(.C_DATA_WIDTH(DW), .C_ID_WIDTH(IW), .C_TIMEOUT(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wr_data(fifo_wr_data),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_vld(fifo_wr_vld), .grant_id(grant_id),
    .busy(busy), .err_timeout(err_timeout));

  eth_fifo_wr_arbiter #(.C_DATA_WIDTH(DW), .C_ID_WIDTH(IW), .C_TIMEOUT(0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(nt_ready), .fifo_wr_data(nt_wr_data),
    .fifo_wr_en(nt_wr_en), .fifo_wr_vld(fifo_wr_vld), .grant_id(nt_grant),
    .busy(nt_busy), .err_timeout(nt_err));

  always #5 clk = ~clk;

  logic [32:0]  sbuf [N][32];
  int           head [N];
  int           tail [N];
  logic [W-1:0] exp_q [$];
  int checks = 0, errors = 0, wr_cnt = 0, to_cnt = 0, n = 0, w0 = 0, t0 = 0;
  bit use_nt = 1'b0;

  function automatic logic [W-1:0] mk(logic e, logic l, logic [IW-1:0] id, logic [DW-1:0] d);
    return {e, l, id, d};
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = head[i] < tail[i];
      req_last[i]            = req_valid[i] ? sbuf[i][head[i]][32] : 1'b0;
      req_data[i*DW +: DW]   = req_valid[i] ? sbuf[i][head[i]][DW-1:0] : '0;
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    exp_q.delete();
    drive_src();
  endtask

  task automatic push_frame(int s, int nb, logic [DW-1:0] base, bit expect_wr, bit last_end);
    for (int b = 0; b < nb; b++) begin
      logic l;
      l = last_end && (b == nb - 1);
      sbuf[s][tail[s]] = {l, base + DW'(b)};
      tail[s]++;
      if (expect_wr) exp_q.push_back(mk(1'b0, l, IW'(s), base + DW'(b)));
    end
  endtask

  // One cycle: observe at negedge, then advance sources after the posedge.
  task automatic tick();
    logic         we, er;
    logic [W-1:0] wd, e;
    logic [N-1:0] acc;
    @(negedge clk);
    we  = use_nt ? nt_wr_en   : fifo_wr_en;
    wd  = use_nt ? nt_wr_data : fifo_wr_data;
    er  = use_nt ? nt_err     : err_timeout;
    acc = req_valid & (use_nt ? nt_ready : req_ready);
    if (er) to_cnt++;
    if (we) begin
      wr_cnt++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write: got %0h expected none", wd);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_data", 64'(wd), 64'(e));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i] && head[i] < tail[i]) head[i]++;
    drive_src();
  endtask

  task automatic run_until(int remain, int max, string tag, output int cnt);
    cnt = 0;
    while (exp_q.size() > remain && cnt < max) begin
      tick();
      cnt++;
    end
    checks++;
    assert (exp_q.size() <= remain) else begin
      errors++;
      $error("FAIL %s_bound: got %0d pending expected %0d", tag, exp_q.size(), remain);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    use_nt = 1'b0;
    fifo_wr_vld = 1'b1;
    clear_src();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    clear_src();
    #1;
    check("rst_wr_en",   64'(fifo_wr_en), 64'd0);
    check("rst_wr_data", 64'(fifo_wr_data), 64'd0);
    check("rst_ready",   64'({req_ready, nt_ready}), 64'd0);
    check("rst_flags",   64'({busy, err_timeout, nt_busy, nt_err}), 64'd0);
    check("rst_grant",   64'(grant_id), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single 4-beat frame from source 0
    push_frame(0, 4, 32'h11, 1'b1, 1'b1);
    run_until(0, 50, "t1", n);
    check("t1_latency", 64'(n), 64'd6);

    // sources 0,1,3 contending with 2-beat frames: strict rotation, one bubble
    apply_reset();
    for (int f = 0; f < 2; f++) begin
      push_frame(0, 2, 32'h100 + 32'(f*16), 1'b1, 1'b1);
      push_frame(1, 2, 32'h200 + 32'(f*16), 1'b1, 1'b1);
      push_frame(3, 2, 32'h300 + 32'(f*16), 1'b1, 1'b1);
    end
    run_until(0, 100, "t2", n);
    check("t2_cycles", 64'(n), 64'd19);

    // FIFO full mid-frame for 20 cycles: held, no abort
    push_frame(0, 4, 32'hA0, 1'b1, 1'b1);
    run_until(2, 50, "t3a", n);
    fifo_wr_vld = 1'b0;
    w0 = wr_cnt;
    t0 = to_cnt;
    repeat (20) tick();
    check("t3_no_wr",  64'(wr_cnt), 64'(w0));
    check("t3_no_to",  64'(to_cnt), 64'(t0));
    check("t3_held",   64'({busy, grant_id}), 64'({1'b1, 2'd0}));
    fifo_wr_vld = 1'b1;
    run_until(0, 50, "t3b", n);
    check("t3_resume", 64'(n), 64'd2);

    // source 2 stalls after beat 2: error beat, then drain, then normal again
    push_frame(2, 2, 32'hB0, 1'b1, 1'b0);
    exp_q.push_back(mk(1'b1, 1'b1, 2'd2, '0));
    t0 = to_cnt;
    run_until(0, 50, "t4a", n);
    check("t4_abort_cyc", 64'(n), 64'd8);
    check("t4_pulse",     64'(to_cnt), 64'(t0 + 1));
    push_frame(2, 5, 32'hC0, 1'b0, 1'b1);
    w0 = wr_cnt;
    n = 0;
    while (head[2] < tail[2] && n < 50) begin
      tick();
      n++;
    end
    check("t4_drained", 64'(tail[2] - head[2]), 64'd0);
    check("t4_drop_nowr", 64'(wr_cnt), 64'(w0));
    push_frame(2, 1, 32'hD0, 1'b1, 1'b1);
    run_until(0, 50, "t4b", n);
    check("t4_rearb",    64'(n), 64'd3);
    check("t4_one_pulse", 64'(to_cnt), 64'(t0 + 1));

    // reset during beat 3 of a 6-beat frame from source 1
    push_frame(1, 6, 32'hE0, 1'b1, 1'b1);
    run_until(4, 50, "t5a", n);
    rst_n = 1'b0;
    #1;
    check("t5_wr_en",   64'(fifo_wr_en), 64'd0);
    check("t5_wr_data", 64'(fifo_wr_data), 64'd0);
    check("t5_ready",   64'(req_ready), 64'd0);
    check("t5_flags",   64'({busy, err_timeout}), 64'd0);
    check("t5_grant",   64'(grant_id), 64'd0);
    clear_src();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_frame(1, 1, 32'h51, 1'b1, 1'b1);
    push_frame(3, 1, 32'h53, 1'b1, 1'b1);
    run_until(0, 50, "t5b", n);
    check("t5_order_cyc", 64'(n), 64'd5);

    // watchdog disabled: 1000-cycle stall keeps the grant
    apply_reset();
    use_nt = 1'b1;
    push_frame(1, 2, 32'h60, 1'b1, 1'b0);
    run_until(0, 50, "t6a", n);
    t0 = to_cnt;
    repeat (1000) tick();
    check("t6_no_to", 64'(to_cnt), 64'(t0));
    check("t6_held",  64'({nt_busy, nt_grant}), 64'({1'b1, 2'd1}));
    push_frame(1, 1, 32'h62, 1'b1, 1'b1);
    run_until(0, 50, "t6b", n);
    check("t6_resume", 64'(n), 64'd2);
    repeat (3) tick();
    check("t6_idle", 64'(nt_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
